// File: rtl/axis_pattern_checker.sv
// AXI-Stream sink that checks an incrementing counter pattern and tlast placement
// against a length latched at start, with a deterministic tready backpressure pattern.
module axis_pattern_checker #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned STALL_EVERY  = 0,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [31:0]           beat_cnt,
    output logic [15:0]           err_data_cnt,
    output logic [15:0]           err_last_cnt,
    output logic [31:0]           first_err_idx
);

    localparam int unsigned CNT_W         = 32;
    localparam int unsigned ERR_W         = 16;
    localparam logic [CNT_W-1:0] NO_ERR   = '1;
    localparam logic [ERR_W-1:0] ERR_SAT  = '1;
    localparam logic [CNT_W-1:0] STALL_N  = CNT_W'(STALL_EVERY);
    localparam logic [CNT_W-1:0] TMR_INIT = CNT_W'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   first_q, first_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   stall_tmr_q, stall_tmr_d;
    logic [ERR_W-1:0]   errd_q, errd_d;
    logic [ERR_W-1:0]   errl_q, errl_d;

    logic hs_c;
    logic data_err_c;
    logic final_idx_c;
    logic last_err_c;
    logic end_beat_c;

    // Per-beat classification of the beat currently on the bus
    always_comb begin
        hs_c        = s_axis_tvalid & (state_q == S_RUN);
        data_err_c  = (s_axis_tdata != DATA_WIDTH'(beat_q));
        final_idx_c = (beat_q == (len_q - CNT_W'(1)));
        // beat index never exceeds len-1 in RUN, so "not final" means "before final"
        last_err_c  = (s_axis_tlast != final_idx_c);
        end_beat_c  = s_axis_tlast | final_idx_c;
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        first_d     = first_q;
        stall_cnt_d = stall_cnt_q;
        stall_tmr_d = stall_tmr_q;
        errd_d      = errd_q;
        errl_d      = errl_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d       = len;
                    beat_d      = '0;
                    first_d     = NO_ERR;
                    stall_cnt_d = '0;
                    errd_d      = '0;
                    errl_d      = '0;
                    state_d     = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hs_c) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (data_err_c && (errd_q != ERR_SAT)) begin
                        errd_d = errd_q + ERR_W'(1);
                    end
                    if (last_err_c && (errl_q != ERR_SAT)) begin
                        errl_d = errl_q + ERR_W'(1);
                    end
                    if ((data_err_c || last_err_c) && (first_q == NO_ERR)) begin
                        first_d = beat_q;
                    end
                    if (end_beat_c) begin
                        state_d = S_DONE;
                    end else if (STALL_N != '0) begin
                        if ((stall_cnt_q + CNT_W'(1)) == STALL_N) begin
                            stall_cnt_d = '0;
                            stall_tmr_d = TMR_INIT;
                            state_d     = S_STALL;
                        end else begin
                            stall_cnt_d = stall_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_STALL: begin
                if (stall_tmr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    stall_tmr_d = stall_tmr_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            first_q     <= NO_ERR;
            stall_cnt_q <= '0;
            stall_tmr_q <= '0;
            errd_q      <= '0;
            errl_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            first_q     <= first_d;
            stall_cnt_q <= stall_cnt_d;
            stall_tmr_q <= stall_tmr_d;
            errd_q      <= errd_d;
            errl_q      <= errl_d;
        end
    end

    // Status decodes of registered state only
    always_comb begin
        s_axis_tready = (state_q == S_RUN);
        busy          = (state_q == S_RUN) || (state_q == S_STALL);
        done          = (state_q == S_DONE);
        pass          = done && (errd_q == '0) && (errl_q == '0) && (beat_q == len_q);
        beat_cnt      = beat_q;
        err_data_cnt  = errd_q;
        err_last_cnt  = errl_q;
        first_err_idx = first_q;
    end

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Bench for axis_pattern_checker: one instance without backpressure, one stalling
// every 4 beats; results compared to a beat-list reference model.
module tb_axis_pattern_checker;

    localparam int unsigned DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_s [2];
    logic [31:0]   len_s   [2];
    logic [DW-1:0] tdata_s [2];
    logic          tvalid_s[2];
    logic          tlast_s [2];
    logic          tready_s[2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          pass_s  [2];
    logic [31:0]   beat_s  [2];
    logic [15:0]   ed_s    [2];
    logic [15:0]   el_s    [2];
    logic [31:0]   fe_s    [2];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pdata[$];
    bit            plast[$];

    axis_pattern_checker #(.DATA_WIDTH(DW), .STALL_EVERY(0), .STALL_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .len(len_s[0]),
        .s_axis_tdata(tdata_s[0]), .s_axis_tvalid(tvalid_s[0]), .s_axis_tlast(tlast_s[0]),
        .s_axis_tready(tready_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .beat_cnt(beat_s[0]), .err_data_cnt(ed_s[0]), .err_last_cnt(el_s[0]),
        .first_err_idx(fe_s[0])
    );

    axis_pattern_checker #(.DATA_WIDTH(DW), .STALL_EVERY(4), .STALL_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .len(len_s[1]),
        .s_axis_tdata(tdata_s[1]), .s_axis_tvalid(tvalid_s[1]), .s_axis_tlast(tlast_s[1]),
        .s_axis_tready(tready_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .beat_cnt(beat_s[1]), .err_data_cnt(ed_s[1]), .err_last_cnt(el_s[1]),
        .first_err_idx(fe_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int d, input logic [31:0] l);
        start_s[d] = 1'b1;
        len_s[d]   = l;
        tick();
        start_s[d] = 1'b0;
    endtask

    // Correct pattern of n beats with tlast on the last one
    task automatic plan_clean(input int n);
        pdata.delete();
        plast.delete();
        for (int i = 0; i < n; i++) begin
            pdata.push_back(DW'(i));
            plast.push_back(i == n - 1);
        end
    endtask

    // Walk the planned beats applying the checking rules directly
    task automatic model(input int L, output int nb, output logic [15:0] ed,
                         output logic [15:0] el, output logic [31:0] fe, output bit ps);
        bit de, le;
        nb = 0; ed = 0; el = 0; fe = 32'hFFFF_FFFF;
        for (int i = 0; i < pdata.size(); i++) begin
            de = (pdata[i] != DW'(i));
            le = (plast[i] && i < L - 1) || (!plast[i] && i == L - 1);
            nb++;
            if (de) ed++;
            if (le) el++;
            if ((de || le) && fe == 32'hFFFF_FFFF) fe = i;
            if (plast[i] || i == L - 1) break;
        end
        ps = (ed == 0) && (el == 0) && (nb == L);
    endtask

    // Start a check, stream the planned beats, then compare all status outputs
    task automatic run_check(input int d, input int L, input bit gaps, input string tag,
                             output int cycles);
        int nb, budget;
        logic [15:0] ed, el;
        logic [31:0] fe;
        bit ps, started;
        cycles = 0;
        started = 0;
        model(L, nb, ed, el, fe, ps);
        do_start(d, L);
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                tvalid_s[d] = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            tdata_s[d]  = pdata[i];
            tlast_s[d]  = plast[i];
            tvalid_s[d] = 1'b1;
            budget = 0;
            while (tready_s[d] !== 1'b1 && budget < 40) begin
                if (started) cycles++;
                tick();
                budget++;
            end
            if (tready_s[d] !== 1'b1) begin
                chk({tag, "_tready_timeout"}, 32'(tready_s[d]), 32'd1);
                tvalid_s[d] = 1'b0;
                return;
            end
            if (i == nb - 1) chk({tag, "_done_early"}, 32'(done_s[d]), 32'd0);
            started = 1;
            cycles++;
            tick();
        end
        tvalid_s[d] = 1'b0;
        tlast_s[d]  = 1'b0;
        chk({tag, "_done"},      32'(done_s[d]),   32'd1);
        chk({tag, "_tready"},    32'(tready_s[d]), 32'd0);
        chk({tag, "_busy"},      32'(busy_s[d]),   32'd0);
        chk({tag, "_beat_cnt"},  beat_s[d],        32'(nb));
        chk({tag, "_err_data"},  32'(ed_s[d]),     32'(ed));
        chk({tag, "_err_last"},  32'(el_s[d]),     32'(el));
        chk({tag, "_first_err"}, fe_s[d],          fe);
        chk({tag, "_pass"},      32'(pass_s[d]),   32'(ps));
    endtask

    initial begin
        int cyc, L, m, k;
        logic tr_seen;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; len_s[d] = '0; tdata_s[d] = '0;
            tvalid_s[d] = 1'b0; tlast_s[d] = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_tready", 32'(tready_s[d]), 32'd0);
            chk("rst_busy",   32'(busy_s[d]),   32'd0);
            chk("rst_done",   32'(done_s[d]),   32'd0);
            chk("rst_pass",   32'(pass_s[d]),   32'd0);
            chk("rst_beat",   beat_s[d],        32'd0);
            chk("rst_errd",   32'(ed_s[d]),     32'd0);
            chk("rst_errl",   32'(el_s[d]),     32'd0);
            chk("rst_first",  fe_s[d],          32'hFFFF_FFFF);
        end

        // Clean 16-beat transfer, no backpressure: 16 back-to-back handshakes
        plan_clean(16);
        run_check(0, 16, 1'b0, "clean16", cyc);
        chk("clean16_cycles", 32'(cyc), 32'd16);

        // Same with stalls of 2 after beats 3, 7, 11 (none after the final beat)
        plan_clean(16);
        run_check(1, 16, 1'b0, "stall16", cyc);
        chk("stall16_cycles", 32'(cyc), 32'(16 + 2 * ((16 - 1) / 4)));

        // Data error on beat 5
        plan_clean(8);
        pdata[5] = DW'(32'h55);
        run_check(0, 8, 1'b0, "data_err", cyc);

        // Early tlast on beat 3
        plan_clean(8);
        plast[3] = 1'b1;
        run_check(0, 8, 1'b0, "early_last", cyc);

        // Missing tlast on final beat
        plan_clean(8);
        plast[7] = 1'b0;
        run_check(0, 8, 1'b0, "missing_last", cyc);

        // Zero length: done the cycle after start, tready never raised
        do_start(0, 32'd0);
        chk("len0_done", 32'(done_s[0]), 32'd1);
        chk("len0_pass", 32'(pass_s[0]), 32'd1);
        chk("len0_beat", beat_s[0],      32'd0);
        tr_seen = tready_s[0];
        repeat (3) begin
            tick();
            tr_seen = tr_seen | tready_s[0];
        end
        chk("len0_tready", 32'(tr_seen), 32'd0);

        // Reset mid-transfer after beat 5, then a fresh check recovers
        do_start(0, 32'd16);
        for (int i = 0; i < 6; i++) begin
            tdata_s[0] = DW'(i); tlast_s[0] = 1'b0; tvalid_s[0] = 1'b1;
            tick();
        end
        tvalid_s[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_done",   32'(done_s[0]),   32'd0);
        chk("midrst_tready", 32'(tready_s[0]), 32'd0);
        chk("midrst_busy",   32'(busy_s[0]),   32'd0);
        chk("midrst_beat",   beat_s[0],        32'd0);
        plan_clean(4);
        run_check(0, 4, 1'b0, "rst_recover", cyc);

        // Randomized transfers on both instances with gaps, corruption and tlast faults
        for (int it = 0; it < 16; it++) begin
            L = $urandom_range(1, 20);
            plan_clean(L);
            m = $urandom_range(0, 5);
            if (m == 0) begin
                k = $urandom_range(0, L - 1);
                plast[k] = 1'b1;
            end else if (m == 1) begin
                plast[L - 1] = 1'b0;
            end
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 7) == 0) pdata[i] = pdata[i] ^ DW'($urandom_range(1, 255));
            end
            run_check(it % 2, L, 1'b1, "rand", cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pattern_checker.md
Name: axis_pattern_checker

Overview:
- Self-checking AXIS sink for the DMA bench: consumes a stream carrying the incrementing counter pattern (beat i carries i, zero-extended), checks data and tlast placement against a length latched at start, and reports pass/fail with error counts.
- Sits on the far end of the pattern source, either directly or through the DMA S2MM→memory→MM2S loop.
- Applies a programmable, deterministic tready backpressure pattern so the source's stall handling gets exercised.

Parameters:
- DATA_WIDTH, 256, tdata width in bits; must be ≥32.
- STALL_EVERY, 0, accepted beats between backpressure windows; 0 disables stalling.
- STALL_CYCLES, 2, length in cycles of each tready-low window; must be ≥1 when STALL_EVERY≠0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse that begins a check; ignored unless idle or done
- len  in  32  expected beat count, sampled on an accepted start
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  stream last
- s_axis_tready  out  1  stream ready
- busy  out  1  high in RUN or STALL
- done  out  1  high in DONE, held until the next accepted start
- pass  out  1  valid while done=1: both error counters are zero and beat_cnt==len
- beat_cnt  out  32  beats accepted in the current check
- err_data_cnt  out  16  data mismatches, saturating at 16'hFFFF
- err_last_cnt  out  16  tlast placement errors, saturating
- first_err_idx  out  32  beat index of the first error of any kind; 32'hFFFFFFFF if none

Behaviour:
- One clock, clk; rst is synchronous and active-high.
- Reset values:
  - State IDLE; s_axis_tready=0; busy=0, done=0, pass=0.
  - beat_cnt=0, both error counters=0, first_err_idx=32'hFFFFFFFF.
  - Reset asserted mid-transfer aborts the check. No done is produced, and the state is IDLE on the cycle after rst is sampled high.
- States: IDLE, RUN, STALL, DONE.
  - s_axis_tready = (state==RUN); it is a decode of registered state only.
  - busy = RUN|STALL.
  - done = (state==DONE).
- Accepted start (state IDLE or DONE):
  - Latches len.
  - Clears beat_cnt, both error counters and first_err_idx.
  - If len==0: enters DONE next cycle with pass=1 and no beats accepted.
  - Otherwise: enters RUN, and tready is high on the cycle after start.
  - start in RUN or STALL is ignored.
- Beat accept (handshake) = tvalid & tready.
  - On each accepted beat at index i=beat_cnt, beat_cnt increments.
  - Data error: tdata ≠ i, compared with i zero-extended to DATA_WIDTH.
  - tlast error: tlast=1 with i<len−1, or tlast=0 with i==len−1.
  - Each error increments its saturating counter.
  - first_err_idx is written with i only when it currently holds 32'hFFFFFFFF.
  - A beat with both a data error and a tlast error increments both counters.
- Transfer end:
  - A beat with tlast=1, or a beat with i==len−1, ends the transfer.
  - State becomes DONE next cycle, so done rises one cycle after the final handshake.
  - Early tlast therefore terminates with beat_cnt<len and pass=0.
  - End of transfer takes priority over entering STALL.
- Backpressure (STALL_EVERY≠0):
  - A stall counter counts accepted beats in RUN.
  - On the beat that makes it equal STALL_EVERY (and that is not the final beat), the counter clears and the next state is STALL.
  - STALL holds tready=0 for exactly STALL_CYCLES cycles, then returns to RUN.
  - The stall counter is cleared on start.
- pass is combinational from registered values; it is meaningful only while done=1 and is 0 otherwise.
- tvalid while tready=0 has no effect. The checker makes no assumption about tdata stability across a stall.

Test Plan:
- STALL_EVERY=0; start with len=16; source drives 0..15 with tlast on beat 15, tvalid continuous → 16 consecutive handshakes; done rises 1 cycle after beat 15; pass=1; beat_cnt=16; first_err_idx=FFFFFFFF.
- STALL_EVERY=4, STALL_CYCLES=2, len=16 → tready low for exactly 2 cycles after beats 3, 7, 11 and not after 15; total 22 cycles from the first tready to the last handshake; pass=1.
- len=8, beat 5 carries 0x55 → err_data_cnt=1, first_err_idx=5, err_last_cnt=0, pass=0.
- len=8, tlast on beat 3 → done after 4 beats; beat_cnt=4; err_last_cnt=1; first_err_idx=3; tready=0 afterwards.
- len=8, no tlast on beat 7 → err_last_cnt=1, first_err_idx=7, done, pass=0. Then, in a separate sequence: start with len=0 → done next cycle, pass=1, tready never high.
- rst pulsed after beat 5 of len=16 → state IDLE next cycle, done=0, tready=0. A new start with len=4 and data 0..3 then passes.
